// File: rtl/m_axi_stream.sv
// m_axi_stream: AXI4-Stream master.
// A start pulse drains exactly len words from a FIFO-style read buffer onto
// the stream. The buffer has a 1-cycle read latency. The final beat carries
// tlast, and done pulses after it. Throughput is one beat per cycle.
//
// Ports:
//   clk, xrst               clock, async active-low reset
//   start, len              transfer request (len latched on accept)
//   busy, done              status: busy while active, done 1-cycle pulse
//   tvalid/tready/tdata     AXI4-Stream master side
//   tstrb/tlast             byte strobes (all ones), final-beat marker
//   buf_isempty/buf_re      read-buffer handshake
//   buf_rdata               read data, valid the cycle after buf_re
module m_axi_stream #(
  parameter int DWIDTH  = 32,
  parameter int BUFSIZE = 10
) (
  input  logic                  clk,
  input  logic                  xrst,
  input  logic                  start,
  input  logic [BUFSIZE:0]      len,
  output logic                  busy,
  output logic                  done,
  output logic                  tvalid,
  input  logic                  tready,
  output logic [DWIDTH-1:0]     tdata,
  output logic [DWIDTH/8-1:0]   tstrb,
  output logic                  tlast,
  input  logic                  buf_isempty,
  output logic                  buf_re,
  input  logic [DWIDTH-1:0]     buf_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_DONE} state_t;

  state_t             state, state_nx;
  logic [BUFSIZE:0]   len_r, issued, sent;
  logic               out_vld, skid_vld, infl, pop, accept;
  logic [DWIDTH-1:0]  skid;
  logic [2:0]         occ;

  assign accept = (state == S_IDLE) && start;
  assign pop    = out_vld && tready;
  assign occ    = {2'b0, out_vld} + {2'b0, skid_vld};
  assign tvalid = out_vld;
  assign tstrb  = '1;
  // sent only moves on a handshake, so tlast is stable while a beat is held
  assign tlast  = out_vld && (sent == len_r - 1'b1);

  // Words held plus the one in flight must leave room for the next return:
  // occ + infl - pop < 2, written without subtraction to avoid underflow.
  assign buf_re = (state == S_SEND) && (issued < len_r) && !buf_isempty &&
                  ((occ + {2'b0, infl}) < (3'd2 + {2'b0, pop}));

  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    busy     = (state != S_IDLE);
    done     = (state == S_DONE);
    case (state)
      S_IDLE: if (start) state_nx = (len == '0) ? S_DONE : S_SEND;
      S_SEND: if (pop && tlast) state_nx = S_DONE;
      S_DONE: state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      len_r    <= '0;
      issued   <= '0;
      sent     <= '0;
      infl     <= 1'b0;
      out_vld  <= 1'b0;
      skid_vld <= 1'b0;
      tdata    <= '0;
      skid     <= '0;
    end else begin
      infl <= buf_re;
      if (accept) begin
        len_r    <= len;
        issued   <= '0;
        sent     <= '0;
        out_vld  <= 1'b0;
        skid_vld <= 1'b0;
      end else begin
        if (buf_re) issued <= issued + 1'b1;
        if (pop)    sent   <= sent + 1'b1;
        // Output reg is always older than skid; skid refills it on a pop,
        // and a returning word lands in the youngest free slot.
        if (pop) begin
          if (skid_vld) begin
            tdata <= skid;
            if (infl) skid     <= buf_rdata;
            else      skid_vld <= 1'b0;
          end else if (infl) begin
            tdata <= buf_rdata;
          end else begin
            out_vld <= 1'b0;
          end
        end else if (infl) begin
          if (!out_vld) begin
            tdata   <= buf_rdata;
            out_vld <= 1'b1;
          end else begin
            skid     <= buf_rdata;
            skid_vld <= 1'b1;
          end
        end
      end
    end
  end

endmodule
